motor_drive: RTL and testbench

Multi-channel H-bridge motor driver: a parametrised successor to the two-channel fixed-mode motor block. Each channel gets its own duty and direction, per-period slew-rate limiting, a dead-time sequence on direction reversal, and an active brake. All channels share one PWM period counter and are phase-aligned. The block sits between the car-control FSM and the L298N-style bridge pins (ENx = pwm, INx1/INx2 = in_pair).

---
 rtl/motor_pkg.sv | 28 ++
 rtl/motor_channel.sv | 118 +++++++++++
 rtl/motor_drive.sv | 82 ++++++++
 tb/tb_motor_drive.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/motor_pkg.sv
// Shared types for the H-bridge motor driver: channel FSM states, bridge IN
// pin encodings and the duty-to-compare conversion.
package motor_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DECEL,
    DEAD,
    BRAKE
  } motor_state_t;

  // IN pair as {INx1, INx2} for a normally mounted motor.
  localparam logic [1:0] IN_FWD   = 2'b10;
  localparam logic [1:0] IN_REV   = 2'b01;
  localparam logic [1:0] IN_COAST = 2'b00;
  localparam logic [1:0] IN_BRAKE = 2'b11;

  // Scales a duty value (full scale 2**duty_w) onto the PWM period.
  function automatic logic [63:0] pwm_cmp(input logic [31:0]  cur,
                                          input logic [31:0]  period,
                                          input int unsigned  duty_w = 10);
    logic [63:0] prod;
    prod = 64'(cur) * 64'(period);
    return prod >> duty_w;
  endfunction

endpackage

// File: rtl/motor_channel.sv
// One bridge channel: run/decel/dead/brake FSM, slew limiter, compare latch
// and registered PWM. Slew limiting is only active when MOTOR_RAMP_EN is defined.
module motor_channel
  import motor_pkg::*;
#(
  parameter int unsigned DUTY_W       = 10,
  parameter int unsigned PERIOD       = 4000,
  parameter int unsigned RAMP_STEP    = 8,
  parameter int unsigned DEAD_PERIODS = 4,
  parameter int unsigned CNT_W        = $clog2(PERIOD)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic [CNT_W-1:0]   cnt_nxt,
  input  logic [DUTY_W-1:0]  duty,
  input  logic               dir,
  input  logic               brake,
  output logic               pwm,
  output logic               at_target,
  output logic               dir_o,
  output motor_state_t       state_o
);

  localparam int unsigned CMP_W = DUTY_W + CNT_W;
  localparam int unsigned DC_W  = $clog2(DEAD_PERIODS + 1);
`ifdef MOTOR_RAMP_EN
  localparam bit RAMP_ON = 1'b1;
`else
  localparam bit RAMP_ON = 1'b0;
`endif
  // Without the ramp the step is full scale, so every update lands on target.
  localparam logic [DUTY_W-1:0] STEP = RAMP_ON ? DUTY_W'(RAMP_STEP) : {DUTY_W{1'b1}};

  motor_state_t      state_q, state_d;
  logic              dir_q, dir_d;
  logic [DUTY_W-1:0] cur_q, cur_d;
  logic [CMP_W-1:0]  cmp_q, cmp_d;
  logic [DC_W-1:0]   dead_q, dead_d;
  logic              pwm_q, pwm_d;
  logic              at_target_q, at_target_d;

  function automatic logic [DUTY_W-1:0] step_to(input logic [DUTY_W-1:0] from,
                                                input logic [DUTY_W-1:0] to);
    if (to >= from) return ((to - from) > STEP) ? from + STEP : to;
    else            return ((from - to) > STEP) ? from - STEP : to;
  endfunction

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    cur_d   = cur_q;
    cmp_d   = cmp_q;
    dead_d  = dead_q;
    if (brake) begin
      state_d = BRAKE;
      cur_d   = '0;
    end else if (tick) begin
      case (state_q)
        IDLE: if (duty != '0) begin
          state_d = RUN;
          dir_d   = dir;
          cur_d   = step_to('0, duty);
        end
        RUN: begin
          if (dir != dir_q) state_d = (cur_q == '0) ? DEAD : DECEL;
          else if (duty == '0 && cur_q == '0) state_d = IDLE;
          else cur_d = step_to(cur_q, duty);
        end
        DECEL: begin
          if (dir == dir_q) begin
            state_d = RUN;
          end else begin
            cur_d = (cur_q > STEP) ? cur_q - STEP : '0;
            if (cur_d == '0) state_d = DEAD;
          end
        end
        DEAD: begin
          if (dead_q == DC_W'(DEAD_PERIODS - 1)) state_d = IDLE;
          else dead_d = dead_q + 1'b1;
        end
        BRAKE:   state_d = DEAD;
        default: state_d = IDLE;
      endcase
    end
    // The dead counter only runs while in DEAD; any other state rearms it.
    if (state_d != DEAD) dead_d = '0;
    if (tick) cmp_d = CMP_W'(pwm_cmp(32'(cur_d), 32'(PERIOD), DUTY_W));
    pwm_d       = (state_d == BRAKE) || ({{DUTY_W{1'b0}}, cnt_nxt} < cmp_d);
    at_target_d = (cur_d == duty) && (state_d == RUN || state_d == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      dir_q       <= 1'b0;
      cur_q       <= '0;
      cmp_q       <= '0;
      dead_q      <= '0;
      pwm_q       <= 1'b0;
      at_target_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      cur_q       <= cur_d;
      cmp_q       <= cmp_d;
      dead_q      <= dead_d;
      pwm_q       <= pwm_d;
      at_target_q <= at_target_d;
    end
  end

  assign pwm       = pwm_q;
  assign at_target = at_target_q;
  assign dir_o     = dir_q;
  assign state_o   = state_q;

endmodule

// File: rtl/motor_drive.sv
// Multi-channel H-bridge driver top: shared phase-aligned PWM counter, period
// tick, per-channel IN encoding and mirror swap. Ramp feature: MOTOR_RAMP_EN.
module motor_drive
  import motor_pkg::*;
#(
  parameter int unsigned          CHANNELS     = 2,
  parameter int unsigned          DUTY_W       = 10,
  parameter int unsigned          CLK_HZ       = 100_000_000,
  parameter int unsigned          PWM_HZ       = 25_000,
  parameter int unsigned          RAMP_STEP    = 8,
  parameter int unsigned          DEAD_PERIODS = 4,
  parameter logic [CHANNELS-1:0]  MIRROR       = CHANNELS'(2'b01)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CHANNELS*DUTY_W-1:0]   duty,
  input  logic [CHANNELS-1:0]          dir,
  input  logic [CHANNELS-1:0]          brake,
  output logic [CHANNELS-1:0]          pwm,
  output logic [2*CHANNELS-1:0]        in_pair,
  output logic [CHANNELS-1:0]          at_target,
  output logic                         period_tick
);

  localparam int unsigned PERIOD = CLK_HZ / PWM_HZ;
  localparam int unsigned CNT_W  = $clog2(PERIOD);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick;

  assign tick = (cnt_q == CNT_W'(PERIOD - 1));

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign period_tick = tick;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    motor_state_t st;
    logic         dq;
    logic [1:0]   in_raw;

    // Channels see the next count so their registered pwm lines up with cnt.
    motor_channel #(
      .DUTY_W       (DUTY_W),
      .PERIOD       (PERIOD),
      .RAMP_STEP    (RAMP_STEP),
      .DEAD_PERIODS (DEAD_PERIODS),
      .CNT_W        (CNT_W)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .tick      (tick),
      .cnt_nxt   (cnt_d),
      .duty      (duty[i*DUTY_W +: DUTY_W]),
      .dir       (dir[i]),
      .brake     (brake[i]),
      .pwm       (pwm[i]),
      .at_target (at_target[i]),
      .dir_o     (dq),
      .state_o   (st)
    );

    always_comb begin
      in_raw = IN_COAST;
      case (st)
        RUN, DECEL: in_raw = dq ? IN_FWD : IN_REV;
        BRAKE:      in_raw = IN_BRAKE;
        default:    in_raw = IN_COAST;
      endcase
    end

    assign in_pair[2*i +: 2] = MIRROR[i] ? {in_raw[0], in_raw[1]} : in_raw;
  end

endmodule

// File: tb/tb_motor_drive.sv
// Directed bench for motor_drive with a 100-cycle PWM period; channel 1 is the
// mirror-mounted one. Expectations cover both MOTOR_RAMP_EN builds.
module tb_motor_drive;

  localparam int PERIOD = 100;
`ifdef MOTOR_RAMP_EN
  localparam bit RAMP = 1'b1;
`else
  localparam bit RAMP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] duty;
  logic [1:0]  dir;
  logic [1:0]  brake;
  logic [1:0]  pwm;
  logic [3:0]  in_pair;
  logic [1:0]  at_target;
  logic        period_tick;

  int n_checks = 0;
  int n_err    = 0;

  motor_drive #(
    .CHANNELS     (2),
    .DUTY_W       (10),
    .CLK_HZ       (2_500_000),
    .PWM_HZ       (25_000),
    .RAMP_STEP    (8),
    .DEAD_PERIODS (4),
    .MIRROR       (2'b10)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .duty        (duty),
    .dir         (dir),
    .brake       (brake),
    .pwm         (pwm),
    .in_pair     (in_pair),
    .at_target   (at_target),
    .period_tick (period_tick)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Scoreboard check
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Driver helpers: advance to cnt = 0 of the next period, or measure one period.
  task automatic next_period();
    int n;
    n = 0;
    while (!period_tick && n < 2 * PERIOD) begin
      @(negedge clk);
      n++;
    end
    chk("tick_wait", 32'(period_tick), 1);
    @(negedge clk);
  endtask

  task automatic measure(output int h0, output int h1);
    h0 = 0;
    h1 = 0;
    for (int i = 0; i < PERIOD; i++) begin
      h0 += int'(pwm[0]);
      h1 += int'(pwm[1]);
      @(negedge clk);
    end
  endtask

  initial begin
    int k, n, h0, h1, s0, s1;
    rst   = 1'b1;
    duty  = '0;
    dir   = 2'b11;
    brake = 2'b00;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_pwm", 32'(pwm), 0);
    chk("rst_in", 32'(in_pair), 0);
    chk("rst_at_target", 32'(at_target), 3);
    chk("rst_tick", 32'(period_tick), 0);
    rst = 1'b0;
    k = 0;
    while (!period_tick && k < 3 * PERIOD) begin
      @(negedge clk);
      k++;
    end
    chk("first_tick_cycle", 32'(k), PERIOD - 1);
    @(negedge clk);

    // Start both channels forward
    duty = {10'd256, 10'd512};
    @(negedge clk);
    chk("at_target_drop", 32'(at_target), 0);
    next_period();
    chk("run_in", 32'(in_pair), 4'b0110);
    chk("run_at_target1", 32'(at_target[1]), RAMP ? 0 : 1);
    measure(h0, h1);
    chk("first_hi0", 32'(h0), RAMP ? 0 : 50);
    chk("first_hi1", 32'(h1), RAMP ? 0 : 25);
    chk("ramp_at_target0", 32'(at_target[0]), RAMP ? 0 : 1);
    repeat (RAMP ? 62 : 0) next_period();
    chk("ramp_done_at_target0", 32'(at_target[0]), 1);
    measure(h0, h1);
    chk("hi0_512", 32'(h0), 50);
    chk("hi1_256", 32'(h1), 25);

    // Ramp down to 64
    duty[9:0] = 10'd64;
    @(negedge clk);
    chk("at_target0_drop", 32'(at_target[0]), 0);
    next_period();
    repeat (RAMP ? 55 : 0) next_period();
    chk("down_at_target0", 32'(at_target[0]), 1);
    measure(h0, h1);
    chk("hi0_64", 32'(h0), 6);

    // Reversal on channel 0
    dir[0] = 1'b0;
    next_period();
    chk("decel_in0", 32'(in_pair[1:0]), 2'b10);
    chk("decel_at_target0", 32'(at_target[0]), 0);
    measure(h0, h1);
    chk("decel_hi0", 32'(h0), 6);
    n = 1;
    while (in_pair[1:0] == 2'b10 && n < 100) begin
      next_period();
      n++;
    end
    chk("decel_periods", 32'(n), RAMP ? 8 : 1);
    n = 0;
    s0 = 0;
    while (in_pair[1:0] == 2'b00 && n < 100) begin
      measure(h0, h1);
      s0 += h0;
      n++;
    end
    chk("coast_periods0", 32'(n), 5);
    chk("coast_hi0", 32'(s0), 0);
    chk("rev_in0", 32'(in_pair[1:0]), 2'b01);
    chk("rev_at_target0", 32'(at_target[0]), RAMP ? 0 : 1);

    // Brake on channel 1 mid-period
    repeat (37) @(negedge clk);
    brake = 2'b10;
    chk("pre_brake_in1", 32'(in_pair[3:2]), 2'b01);
    @(negedge clk);
    chk("brake_in1", 32'(in_pair[3:2]), 2'b11);
    chk("brake_pwm1", 32'(pwm[1]), 1);
    chk("brake_at_target1", 32'(at_target[1]), 0);
    chk("brake_in0", 32'(in_pair[1:0]), 2'b01);
    repeat (30) @(negedge clk);
    chk("brake_pwm1_late", 32'(pwm[1]), 1);
    next_period();
    chk("brake_hold_in1", 32'(in_pair[3:2]), 2'b11);
    brake = 2'b00;
    @(negedge clk);
    chk("brake_release_in1", 32'(in_pair[3:2]), 2'b11);
    next_period();
    n = 0;
    s1 = 0;
    while (in_pair[3:2] == 2'b00 && n < 100) begin
      measure(h0, h1);
      s1 += h1;
      n++;
    end
    chk("coast_periods1", 32'(n), 5);
    chk("coast_hi1", 32'(s1), 0);
    chk("restart_in1", 32'(in_pair[3:2]), 2'b01);

    // Asynchronous reset mid-period
    repeat (34) @(negedge clk);
    chk("pre_rst_in", 32'(in_pair), 4'b0101);
    #2 rst = 1'b1;
    #1;
    chk("arst_in", 32'(in_pair), 0);
    chk("arst_pwm", 32'(pwm), 0);
    chk("arst_at_target", 32'(at_target), 3);
    chk("arst_tick", 32'(period_tick), 0);
    duty = {10'd1023, 10'd1000};
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    chk("idle_after_rst", 32'(in_pair), 0);
    k = 50;
    while (!period_tick && k < 3 * PERIOD) begin
      @(negedge clk);
      k++;
    end
    chk("rst_tick_cycle", 32'(k), PERIOD - 1);
    @(negedge clk);
    chk("rerun_in", 32'(in_pair), 4'b0101);
    measure(h0, h1);
    chk("full_hi0", 32'(h0), RAMP ? 0 : 97);
    chk("full_hi1", 32'(h1), RAMP ? 0 : 99);

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
